// File: rtl/mantissa_mul_pkg.sv
// -----------------------------------------------------------------------------
// mantissa_mul_pkg
// Shared types and constants for the mantissa multiplier arbiter.
//   arb_state_t : controller state (IDLE, MUL, PIPE, RESP)
//   N_DEFAULT   : default mantissa width, hidden bit included
//   TXN_CNT_W   : width of the completed-transaction counter
// -----------------------------------------------------------------------------
package mantissa_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        PIPE = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam int N_DEFAULT = 11;
    localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/mantissa_mul_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at index ptr and
// walks upward modulo NREQ; the first asserted request wins.
// Ports:
//   req   [NREQ-1:0]  : request vector
//   ptr   [PTR_W-1:0] : highest-priority index for this search
//   grant [NREQ-1:0]  : one-hot grant, all-zero when req is all-zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Rotate the search origin to ptr without a modulo operator.
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mantissa_mul_arbiter.sv
// -----------------------------------------------------------------------------
// mantissa_mul_arbiter
// Shares one unsigned N x N mantissa multiplier among NREQ requesters.
// Flow: IDLE (grant + capture) -> MUL -> [PIPE] -> RESP (hold until accepted).
//
// Optional build macro:
//   MANTISSA_MUL_PIPE_EN : adds the PIPE state, re-registering the product for
//                          one extra cycle (latency 3 instead of 2).
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   req_valid   [NREQ]   : requester has operands
//   req_ready   [NREQ]   : one-hot accept, only in IDLE and only out of reset
//   req_a/req_b [NREQ*N] : operands, requester i at bits [i*N +: N]
//   resp_valid  [NREQ]   : product available for the owning requester
//   resp_ready  [NREQ]   : product accepted; only the owner's bit is used
//   resp_data   [2N]     : full product, shared bus
//   busy                 : controller not in IDLE
//   txn_count   [16]     : completed transactions, wraps
//   dbg_state            : current controller state
//
// Handshake: a transfer happens on the rising edge where valid and ready are
// both high. Requesters hold valid and operands stable until accepted; the
// product is held on resp_data with resp_valid high until resp_ready of the
// owner is seen.
// -----------------------------------------------------------------------------
module mantissa_mul_arbiter
    import mantissa_mul_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [2*N-1:0]       resp_data,
    output logic                 busy,
    output logic [TXN_CNT_W-1:0] txn_count,
    output arb_state_t           dbg_state
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] grant_idx;
    logic [2*N-1:0]   product;
`ifdef MANTISSA_MUL_PIPE_EN
    logic [2*N-1:0]   prod_q;
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // One-hot grant to index; at most one bit is set.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // The single shared multiplier; zero-extended so no product bit is lost.
    assign product = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};

    // Gated by rst so nothing is offered while reset is held.
    assign req_ready = (rst && (state == IDLE)) ? grant : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            txn_count  <= '0;
`ifdef MANTISSA_MUL_PIPE_EN
            prod_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        op_a  <= req_a[grant_idx*N +: N];
                        op_b  <= req_b[grant_idx*N +: N];
                        owner <= grant_idx;
                        state <= MUL;
                    end
                end
                MUL: begin
`ifdef MANTISSA_MUL_PIPE_EN
                    prod_q     <= product;
                    state      <= PIPE;
`else
                    resp_data  <= product;
                    resp_valid <= NREQ'(1) << owner;
                    state      <= RESP;
`endif
                end
`ifdef MANTISSA_MUL_PIPE_EN
                PIPE: begin
                    resp_data  <= prod_q;
                    resp_valid <= NREQ'(1) << owner;
                    state      <= RESP;
                end
`endif
                RESP: begin
                    // Only the owner's resp_ready can complete the transfer.
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        ptr        <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                        txn_count  <= txn_count + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mantissa_mul_arbiter
// Self-checking bench. Requesters are modelled as pending operand slots; a
// transaction-level reference (round-robin pick, product, latency count,
// completion) predicts every output each cycle. Directed scenarios then check
// fixed values: single request, maximum operands, grant order, back-pressure,
// and asynchronous reset during a multiply.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mantissa_mul_arbiter;
    import mantissa_mul_pkg::*;

    localparam int N    = 11;
    localparam int NREQ = 4;
`ifdef MANTISSA_MUL_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [2*N-1:0]       resp_data;
    logic                 busy;
    logic [TXN_CNT_W-1:0] txn_count;
    arb_state_t           dbg_state;

    mantissa_mul_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .txn_count  (txn_count),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [NREQ-1:0] pend_v;
    logic [N-1:0]    pend_a [NREQ];
    logic [N-1:0]    pend_b [NREQ];
    int              gen_mode;   // 0 none, 1 random arrivals, 2 always requesting
    int              rr_mode;    // 0 all ready, 1 random, 2 none, 3 all but owner

    bit              m_active;
    int              m_owner;
    int              m_age;
    int              m_ptr;
    logic [15:0]     m_count;
    logic [2*N-1:0]  exp_q [$];
    int              grant_log [$];
    int              acc_log [$];
    int              cyc;
    int              accept_cyc;
    int              resp_cyc;
    logic [2*N-1:0]  last_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 11'h7FF;
            2:       return 11'h400;
            default: return N'($urandom_range(0, (1 << N) - 1));
        endcase
    endfunction

    // First pending requester at or above p, wrapping modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active   = 1'b0;
        m_owner    = 0;
        m_age      = 0;
        m_ptr      = 0;
        m_count    = '0;
        exp_q.delete();
        grant_log.delete();
        acc_log.delete();
        accept_cyc = -1;
        resp_cyc   = -1;
        last_resp  = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        req_valid = pend_v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = pend_a[i];
            req_b[i*N +: N] = pend_b[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        pend_v     = '0;
        resp_ready = '0;
        drive_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at the falling edge, check, then advance the model
    // with the inputs held across the rising edge.
    task automatic step_body();
        int              win;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        logic [2*N-1:0]  pa;
        logic [2*N-1:0]  pb;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend_v[i] && (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 3) == 0))) begin
                pend_v[i] = 1'b1;
                pend_a[i] = rand_op();
                pend_b[i] = rand_op();
            end
        end
        case (rr_mode)
            0:       resp_ready = '1;
            1:       resp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            2:       resp_ready = '0;
            default: resp_ready = m_active ? ~(NREQ'(1) << m_owner) : '1;
        endcase
        drive_inputs();
        #1;
        win       = m_active ? -1 : rr_pick(pend_v, m_ptr);
        exp_ready = (win >= 0) ? (NREQ'(1) << win) : '0;
        exp_rv    = (m_active && m_age >= LAT) ? (NREQ'(1) << m_owner) : '0;
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, exp_rv);
        check("busy", busy, m_active);
        check("txn_count", txn_count, m_count);
        if (exp_rv != 0 && exp_q.size() > 0) check("resp_data", resp_data, exp_q[0]);
        if (resp_valid != 0) begin
            if (resp_cyc < 0) resp_cyc = cyc;
            last_resp = resp_data;
        end
        @(posedge clk);
        cyc++;
        if (win >= 0) begin
            m_active = 1'b1;
            m_owner  = win;
            m_age    = 1;
            pa       = pend_a[win];
            pb       = pend_b[win];
            exp_q.push_back(pa * pb);
            pend_v[win] = 1'b0;
            grant_log.push_back(win);
            acc_log.push_back(cyc - 1);
            if (accept_cyc < 0) accept_cyc = cyc - 1;
        end else if (m_active) begin
            if (m_age >= LAT) begin
                if (resp_ready[m_owner]) begin
                    m_active = 1'b0;
                    m_ptr    = (m_owner + 1) % NREQ;
                    m_count  = m_count + 1'b1;
                    void'(exp_q.pop_front());
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        step_body();
    endtask

    // ---------------- main sequence ----------------
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int guard;

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        gen_mode   = 0;
        rr_mode    = 0;
        pend_v     = '0;
        cyc        = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        model_reset();
        #1 rst = 1'b0;
        #11;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_resp_data", resp_data, 22'h0);
        check("rst_txn_count", txn_count, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, IDLE);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // Single request 0x400 * 0x400.
        pend_v[0] = 1'b1; pend_a[0] = 11'h400; pend_b[0] = 11'h400;
        repeat (6) step();
        #1;
        check("single_accept_cycle", accept_cyc, 0);
        check("single_latency", resp_cyc - accept_cyc, LAT);
        check("single_data", last_resp, 22'h100000);
        check("single_count", txn_count, 16'd1);

        // Maximum operands.
        do_reset();
        pend_v[2] = 1'b1; pend_a[2] = 11'h7FF; pend_b[2] = 11'h7FF;
        repeat (6) step();
        #1;
        check("max_latency", resp_cyc - accept_cyc, LAT);
        check("max_data", last_resp, 22'h3FF001);

        // All requesters always asking: order and throughput.
        do_reset();
        gen_mode = 2; rr_mode = 0;
        guard = 0;
        while (m_count < 5 && guard < 60) begin
            step();
            guard++;
        end
        #1;
        gen_mode = 0;
        check("rr_count", txn_count, 16'd5);
        if (grant_log.size() >= 5 && acc_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("rr_order_%0d", k), grant_log[k], exp_order[k]);
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rr_spacing_%0d", k), acc_log[k+1] - acc_log[k], LAT + 1);
            end
        end else begin
            check("rr_grants_seen", grant_log.size(), 5);
        end

        // Back-pressure with other requesters waiting.
        do_reset();
        pend_v[2] = 1'b1; pend_a[2] = rand_op(); pend_b[2] = rand_op();
        guard = 0;
        while (!m_active && guard < 5) begin
            step();
            guard++;
        end
        pend_v[0] = 1'b1; pend_a[0] = rand_op(); pend_b[0] = rand_op();
        pend_v[1] = 1'b1; pend_a[1] = rand_op(); pend_b[1] = rand_op();
        rr_mode = 2;
        repeat (6) step();
        rr_mode = 3;
        repeat (6) step();
        #1;
        check("bp_valid_held", resp_valid, 4'b0100);
        check("bp_count_held", txn_count, 16'd0);
        rr_mode = 0;
        step();
        #1;
        check("bp_done_count", txn_count, 16'd1);
        check("bp_done_valid", resp_valid, 4'b0000);
        repeat (8) step();
        if (grant_log.size() >= 3) begin
            check("bp_next_grant", grant_log[1], 0);
            check("bp_third_grant", grant_log[2], 1);
        end else begin
            check("bp_grants_seen", grant_log.size(), 3);
        end

        // Asynchronous reset while multiplying.
        do_reset();
        pend_v[1] = 1'b1; pend_a[1] = rand_op(); pend_b[1] = rand_op();
        guard = 0;
        while (!m_active && guard < 5) begin
            step();
            guard++;
        end
        @(negedge clk);
        pend_v[3] = 1'b1; pend_a[3] = 11'h7FF; pend_b[3] = 11'h001;
        drive_inputs();
        #1 rst = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 4'b0000);
        check("arst_busy", busy, 1'b0);
        check("arst_resp_data", resp_data, 22'h0);
        check("arst_req_ready", req_ready, 4'b0000);
        check("arst_state", dbg_state, IDLE);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_hold_ready", req_ready, 4'b0000);
        check("arst_hold_valid", resp_valid, 4'b0000);
        check("arst_hold_count", txn_count, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        step_body();
        repeat (6) step();
        #1;
        check("arst_next_count", txn_count, 16'd1);
        check("arst_next_data", last_resp, 22'h0007FF);
        if (grant_log.size() >= 1) check("arst_next_owner", grant_log[0], 3);
        else check("arst_grants_seen", grant_log.size(), 1);

        // Randomised traffic against the reference model.
        do_reset();
        gen_mode = 1; rr_mode = 1;
        repeat (800) step();
        gen_mode = 0; rr_mode = 0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
